integer_multiplication_unit: RTL and testbench

Iterative radix-2 shift-add multiplier for the RV32M multiply group (MUL, MULH, MULHSU, MULHU) in the execute stage. It is the multiply counterpart of the integer division unit and shares its operand conventions and 64-bit product output. It accepts one operation per start pulse and computes over a fixed 33-cycle latency. It reports completion with a one-cycle done pulse.

---
 rtl/integer_multiplication_unit_pkg.sv | 21 ++
 rtl/integer_multiplication_unit_if.sv | 22 ++
 rtl/integer_multiplication_unit_step.sv | 18 +
 rtl/integer_multiplication_unit.sv | 102 ++++++++++
 tb/tb_integer_multiplication_unit.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/integer_multiplication_unit_pkg.sv
// Shared encodings for the multiply unit: op codes, FSM states and default width.
// The division unit uses the same op-code and state layout.
package integer_multiplication_unit_pkg;

  localparam int MDU_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mul_state_e;

endpackage

// File: rtl/integer_multiplication_unit_if.sv
// Request/response bundle between the execute stage and the multiply unit.
interface integer_multiplication_unit_if #(parameter int DW = 32);
  logic            start_i;
  logic            flush_i;
  logic [1:0]      op_i;
  logic [DW-1:0]   operand1_i;
  logic [DW-1:0]   operand2_i;
  logic            busy_o;
  logic            done_o;
  logic [DW-1:0]   result_o;
  logic [2*DW-1:0] product_o;

  modport master (
    output start_i, flush_i, op_i, operand1_i, operand2_i,
    input  busy_o, done_o, result_o, product_o
  );

  modport slave (
    input  start_i, flush_i, op_i, operand1_i, operand2_i,
    output busy_o, done_o, result_o, product_o
  );
endinterface

// File: rtl/integer_multiplication_unit_step.sv
// One radix-2 shift-add iteration. The multiplier sits in the low half of the
// accumulator, so its current bit is always acc_i[0].
module mul_shift_add_step #(
  parameter int DW = 32
) (
  input  logic [2*DW-1:0] acc_i,
  input  logic [DW-1:0]   mcand_i,
  output logic [2*DW-1:0] acc_o
);
  logic [DW:0] sum;

  always_comb begin
    sum = {1'b0, acc_i[2*DW-1:DW]};
    if (acc_i[0]) sum = sum + {1'b0, mcand_i};
    // carry becomes the new MSB as {carry, acc} shifts right by one
    acc_o = {sum, acc_i[DW-1:1]};
  end
endmodule

// File: rtl/integer_multiplication_unit.sv
// Iterative RV32M multiplier: sign-magnitude on accept, 32 shift-add steps,
// one sign-fix cycle, then a one-cycle done pulse.
module integer_multiplication_unit
  import integer_multiplication_unit_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
  input logic clk_i,
  input logic rst_i,
  integer_multiplication_unit_if.slave bus
);
  localparam int DW    = DATA_WIDTH;
  localparam int CNT_W = $clog2(DW);

  mul_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]   mcand_q;
  logic [2*DW-1:0] acc_q, acc_nxt;
  logic            neg_q;
  mul_op_e         op_q;
  logic            busy_q, busy_d, done_q, done_d;
  logic [2*DW-1:0] prod_q, prod_fix;
  logic [DW-1:0]   res_q;

  logic            accept, sign1, sign2;
  logic [DW-1:0]   mag1, mag2;

  assign accept = (state_q == ST_IDLE) && bus.start_i && !bus.flush_i;

  // MUL runs unsigned: the low word does not depend on operand signedness
  assign sign1 = ((bus.op_i == MUL_OP_MULH) || (bus.op_i == MUL_OP_MULHSU)) && bus.operand1_i[DW-1];
  assign sign2 = (bus.op_i == MUL_OP_MULH) && bus.operand2_i[DW-1];
  assign mag1  = sign1 ? (~bus.operand1_i + 1'b1) : bus.operand1_i;
  assign mag2  = sign2 ? (~bus.operand2_i + 1'b1) : bus.operand2_i;

  assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;

  mul_shift_add_step #(.DW(DW)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_nxt)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_CALC;
      ST_CALC: if (cnt_q == CNT_W'(DW-1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush_i) state_d = ST_IDLE;
  end

  // Status flags are decoded from the next state and registered.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      op_q    <= MUL_OP_MUL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
      res_q   <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (accept) begin
        cnt_q   <= '0;
        mcand_q <= mag1;
        acc_q   <= {{DW{1'b0}}, mag2};
        neg_q   <= sign1 ^ sign2;
        op_q    <= mul_op_e'(bus.op_i);
      end else if (state_q == ST_CALC) begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == ST_FIX && !bus.flush_i) begin
        prod_q <= prod_fix;
        res_q  <= (op_q == MUL_OP_MUL) ? prod_fix[DW-1:0] : prod_fix[2*DW-1:DW];
      end
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.result_o  = res_q;
  assign bus.product_o = prod_q;
endmodule

// File: tb/tb_integer_multiplication_unit.sv
// Self-checking bench for the iterative multiplier: directed corner cases,
// randomized ops against an arithmetic model, flush, async reset, held start.
module tb_integer_multiplication_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  integer_multiplication_unit_if #(.DW(32)) bus();

  integer_multiplication_unit #(.DATA_WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  function automatic logic [63:0] ref_prod(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
    sb = (op == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(sa * sb);
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [63:0] p);
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Drive one request, wait (bounded) for done, then one more edge so the unit is idle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit ok);
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = op; bus.operand1_i = a; bus.operand2_i = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    lat = 0; ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done_o) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.busy_o, bus.done_o} !== 2'b00 || bus.result_o !== 32'h0 || bus.product_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b done=%b result=%h product=%h, required all zero",
               bus.busy_o, bus.done_o, bus.result_o, bus.product_o);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [6] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b01};
    logic [31:0] as  [6] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] bs  [6] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [63:0] eps [6] = '{64'h0000_0006_FFFF_FFEB, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFE_0000_0001, 64'h0};
    logic [31:0] ers [6] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0};
    int lat; bit ok;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], as[i], bs[i], lat, ok);
      n_checks++;
      if (!ok || lat != 33) begin
        n_fail++;
        $display("FAIL directed_latency case %0d got done=%b after %0d cycles, required 33", i, ok, lat);
      end
      n_checks++;
      if (bus.product_o !== eps[i] || bus.result_o !== ers[i]) begin
        n_fail++;
        $display("FAIL directed_value case %0d product=%h result=%h, required %h %h",
                 i, bus.product_o, bus.result_o, eps[i], ers[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat; bit ok;
    logic [1:0] op; logic [31:0] a, b; logic [63:0] ep;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3)); a = pick_operand(); b = pick_operand();
      ep = ref_prod(op, a, b);
      do_op(op, a, b, lat, ok);
      n_checks++;
      if (!ok || bus.product_o !== ep || bus.result_o !== ref_res(op, ep)) begin
        n_fail++;
        $display("FAIL random op=%0d a=%h b=%h done=%b product=%h result=%h, required %h %h",
                 op, a, b, ok, bus.product_o, bus.result_o, ep, ref_res(op, ep));
      end
    end
  endtask

  task automatic test_flush();
    int lat; bit ok; int seen_done;
    logic [31:0] prev;
    do_op(2'b00, 32'd12345, 32'd678, lat, ok);
    prev = bus.result_o;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b11; bus.operand1_i = 32'hDEAD_BEEF; bus.operand2_i = 32'h1234_5678;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    seen_done = 0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.done_o) seen_done++;
    end
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    if (bus.done_o) seen_done++;
    n_checks++;
    if (bus.busy_o !== 1'b0 || seen_done != 0) begin
      n_fail++;
      $display("FAIL flush_abort busy=%b done_pulses=%0d, required busy 0 and no done", bus.busy_o, seen_done);
    end
    n_checks++;
    if (bus.result_o !== prev) begin
      n_fail++;
      $display("FAIL flush_hold result=%h, required %h", bus.result_o, prev);
    end
    do_op(2'b10, 32'hFFFF_FFF0, 32'd3, lat, ok);
    n_checks++;
    if (!ok || lat != 33 || bus.product_o !== ref_prod(2'b10, 32'hFFFF_FFF0, 32'd3)) begin
      n_fail++;
      $display("FAIL flush_restart done=%b lat=%0d product=%h, required %h",
               ok, lat, bus.product_o, ref_prod(2'b10, 32'hFFFF_FFF0, 32'd3));
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit ok;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b01; bus.operand1_i = 32'h1357_9BDF; bus.operand2_i = 32'h8642_0ACE;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy_o, bus.done_o} !== 2'b00 || bus.result_o !== 32'h0 || bus.product_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mid busy=%b done=%b result=%h product=%h, required all zero",
               bus.busy_o, bus.done_o, bus.result_o, bus.product_o);
    end
    @(negedge clk); rst_n = 1'b1;
    do_op(2'b01, 32'hFFFF_FFFE, 32'd5, lat, ok);
    n_checks++;
    if (!ok || bus.result_o !== ref_res(2'b01, ref_prod(2'b01, 32'hFFFF_FFFE, 32'd5))) begin
      n_fail++;
      $display("FAIL reset_recover done=%b result=%h, required %h", ok, bus.result_o,
               ref_res(2'b01, ref_prod(2'b01, 32'hFFFF_FFFE, 32'd5)));
    end
  endtask

  task automatic test_back_to_back();
    int pulses; logic [63:0] ep;
    ep = ref_prod(2'b11, 32'hCAFE_F00D, 32'h0BAD_F00D);
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b11; bus.operand1_i = 32'hCAFE_F00D; bus.operand2_i = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.op_i = 2'b00; bus.operand1_i = 32'h1; bus.operand2_i = 32'h1;
    pulses = 0;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      if (bus.done_o) pulses++;
    end
    bus.start_i = 1'b0;
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL held_start_pulses got %0d done pulses, required 1", pulses);
    end
    n_checks++;
    if (bus.product_o !== ep || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL held_start_value product=%h busy=%b, required %h and 0", bus.product_o, bus.busy_o, ep);
    end
  endtask

  initial begin
    bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.op_i = 2'b00;
    bus.operand1_i = '0; bus.operand2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
